dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: the CPU MEM stage (requester 0) and a DMA/debug loader (requester 1).
- The CPU has priority. A starvation counter forces a DMA slot after STARVE_LIMIT consecutive CPU wins against a waiting DMA.
- The CPU loses the bus only on a forced slot. It then receives cpu_stall, which the top level ORs into PC_Hold, IF_ID_Hold and the EX/MEM/WB hold controls.

---
 rtl/dmem_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU MEM stage has priority, a DMA/debug loader gets a
// forced slot after STARVE_LIMIT consecutive CPU wins against a waiting DMA.
module dmem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic [3:0] streak, streak_nxt;
   logic [4:0] streak_inc;
   logic       force_dma, force_dma_nxt;
   logic       sel_dma;

   // force_dma is cleared by the async reset, so during reset a CPU request wins.
   assign sel_dma   = dma_req & (force_dma | ~cpu_req);
   assign dma_gnt   = sel_dma;
   assign cpu_stall = cpu_req & sel_dma;
   assign cpu_rdata = mem_rdata;

   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_read  = cpu_req & ~cpu_we;
      mem_write = cpu_req & cpu_we;
      if (sel_dma) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_read  = ~dma_we;
         mem_write = dma_we;
      end
   end

   always_comb begin
      streak_nxt    = streak;
      force_dma_nxt = force_dma;
      streak_inc    = {1'b0, streak} + 5'd1;
      if (!dma_req || sel_dma) begin
         streak_nxt    = '0;
         force_dma_nxt = 1'b0;
      end else if (cpu_req) begin
         // CPU beat a waiting DMA; the LIMIT-th such win owes the DMA the next slot.
         if (streak_inc == 5'(STARVE_LIMIT)) begin
            streak_nxt    = '0;
            force_dma_nxt = 1'b1;
         end else begin
            streak_nxt = streak_inc[3:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         streak     <= '0;
         force_dma  <= 1'b0;
         dma_rvalid <= 1'b0;
         dma_rdata  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
         streak     <= streak_nxt;
         force_dma  <= force_dma_nxt;
         dma_rvalid <= sel_dma & ~dma_we;
         if (sel_dma & ~dma_we) dma_rdata <= mem_rdata;
      end
   end

endmodule
